// File: rtl/vx_reseed_pkg.sv
// Shared state encoding and default widths for the dcache reseed controller.
package vx_reseed_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESEED = 2'd2,
    ST_SETTLE = 2'd3
  } reseed_state_e;

  localparam int RESEED_NUM_REQUESTS  = 4;
  localparam int RESEED_INTERVAL_W    = 24;
  localparam int RESEED_OUTST_W       = 8;
  localparam int RESEED_SETTLE_CYCLES = 4;
endpackage

// File: rtl/vx_popcount.sv
// Combinational population count of an N-bit lane mask.
module vx_popcount
  import vx_reseed_pkg::*;
#(
  parameter int N = RESEED_NUM_REQUESTS
) (
  input  logic [N-1:0]             i_bits,
  output logic [$clog2(N+1)-1:0]   o_cnt
);
  localparam int CW = $clog2(N+1);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < N; i++) begin
      o_cnt = o_cnt + CW'(i_bits[i]);
    end
  end
endmodule

// File: rtl/vx_dcache_reseed_ctrl.sv
// Gates core dcache requests, drains outstanding reads, then pulses a placement reseed.
// Optional VX_RESEED_PERF_EN adds reseed and stall performance counters.
module vx_dcache_reseed_ctrl
  import vx_reseed_pkg::*;
#(
  parameter int NUM_REQUESTS  = RESEED_NUM_REQUESTS,
  parameter int INTERVAL_W    = RESEED_INTERVAL_W,
  parameter int OUTST_W       = RESEED_OUTST_W,
  parameter int SETTLE_CYCLES = RESEED_SETTLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INTERVAL_W-1:0]   cfg_interval,
  input  logic                    reseed_req,
  input  logic [NUM_REQUESTS-1:0] req_valid_in,
  input  logic [NUM_REQUESTS-1:0] req_rw_in,
  output logic                    req_ready_in,
  output logic [NUM_REQUESTS-1:0] req_valid_out,
  input  logic                    req_ready_out,
  input  logic [NUM_REQUESTS-1:0] rsp_valid,
  input  logic                    rsp_ready,
  output logic                    reseed,
  output logic                    busy
`ifdef VX_RESEED_PERF_EN
  ,
  output logic [31:0]             perf_reseeds,
  output logic [31:0]             perf_stall_cycles
`endif
);
  localparam int PCW = $clog2(NUM_REQUESTS+1);
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  reseed_state_e         r_state, w_state_nxt;
  logic [SW-1:0]         r_settle, w_settle_nxt;
  logic                  r_pending, w_pending_nxt;
  logic [INTERVAL_W-1:0] r_icnt, w_icnt_nxt;
  logic [OUTST_W-1:0]    r_outst, w_outst_nxt;

  logic                  w_open, w_fire, w_rsp_acc;
  logic [PCW-1:0]        w_acc_cnt, w_rsp_cnt, w_add_cnt, w_sub_cnt;
  logic [OUTST_W:0]      w_up, w_dn, w_diff;
  logic                  w_ovf, w_udf;

  assign w_open        = (r_state == ST_IDLE) & ~reset;
  assign req_valid_out = req_valid_in & {NUM_REQUESTS{w_open}};
  assign req_ready_in  = req_ready_out & w_open;
  assign w_fire        = w_open & (|req_valid_in) & req_ready_out;
  assign w_rsp_acc     = (|rsp_valid) & rsp_ready;
  assign reseed        = (r_state == ST_RESEED) & ~reset;
  assign busy          = (r_state != ST_IDLE) & ~reset;

  vx_popcount #(.N(NUM_REQUESTS)) u_pc_acc (
    .i_bits (req_valid_in & ~req_rw_in),
    .o_cnt  (w_acc_cnt)
  );

  vx_popcount #(.N(NUM_REQUESTS)) u_pc_rsp (
    .i_bits (rsp_valid),
    .o_cnt  (w_rsp_cnt)
  );

  // Outstanding reads: one extra bit of headroom to detect over/underflow before saturating.
  assign w_add_cnt   = w_fire    ? w_acc_cnt : '0;
  assign w_sub_cnt   = w_rsp_acc ? w_rsp_cnt : '0;
  assign w_up        = {1'b0, r_outst} + (OUTST_W+1)'(w_add_cnt);
  assign w_dn        = (OUTST_W+1)'(w_sub_cnt);
  assign w_udf       = w_dn > w_up;
  assign w_diff      = w_up - w_dn;
  assign w_ovf       = ~w_udf & w_diff[OUTST_W];
  assign w_outst_nxt = w_udf ? '0 : (w_ovf ? '1 : w_diff[OUTST_W-1:0]);

  assign w_icnt_nxt  = (w_fire && !(&r_icnt)) ? r_icnt + 1'b1 : r_icnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_settle  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_settle  <= w_settle_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle;
    w_pending_nxt = r_pending | reseed_req;
    case (r_state)
      ST_IDLE: begin
        if (r_pending || reseed_req ||
            (cfg_interval != '0 && w_icnt_nxt >= cfg_interval)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_outst == '0) begin
          w_state_nxt   = ST_RESEED;
          w_pending_nxt = 1'b0;
        end
      end
      ST_RESEED: begin
        w_state_nxt   = ST_SETTLE;
        w_settle_nxt  = '0;
        w_pending_nxt = 1'b0;
      end
      ST_SETTLE: begin
        // Requests arriving while closed are absorbed by the reseed already under way.
        w_pending_nxt = 1'b0;
        if (r_settle == SW'(SETTLE_CYCLES-1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icnt  <= '0;
      r_outst <= '0;
    end else begin
      r_icnt  <= (r_state == ST_RESEED) ? '0 : w_icnt_nxt;
      r_outst <= w_outst_nxt;
    end
  end

`ifdef VX_RESEED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reseeds      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (r_state == ST_RESEED) perf_reseeds <= perf_reseeds + 32'd1;
      if ((|req_valid_in) && !w_open) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  a_outst_ovf: assert property (@(posedge clk) disable iff (reset) !w_ovf);
  a_outst_udf: assert property (@(posedge clk) disable iff (reset) !w_udf);
endmodule

// File: tb/tb_vx_dcache_reseed_ctrl.sv
// Directed self-checking bench for vx_dcache_reseed_ctrl (default parameters).
module tb_vx_dcache_reseed_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cfg_interval;
  logic        reseed_req;
  logic [3:0]  req_valid_in, req_rw_in, req_valid_out, rsp_valid;
  logic        req_ready_in, req_ready_out, rsp_ready, reseed, busy;
`ifdef VX_RESEED_PERF_EN
  logic [31:0] perf_reseeds, perf_stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int base    = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (reseed === 1'b1) pulses++;

  vx_dcache_reseed_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_interval  (cfg_interval),
    .reseed_req    (reseed_req),
    .req_valid_in  (req_valid_in),
    .req_rw_in     (req_rw_in),
    .req_ready_in  (req_ready_in),
    .req_valid_out (req_valid_out),
    .req_ready_out (req_ready_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .reseed        (reseed),
    .busy          (busy)
`ifdef VX_RESEED_PERF_EN
    ,
    .perf_reseeds      (perf_reseeds),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    reseed_req   = 1'b0;
    req_valid_in = 4'b0000;
    req_rw_in    = 4'b0000;
    rsp_valid    = 4'b0000;
    rsp_ready    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_interval = '0; req_ready_out = 1'b1;
    idle_in();
    cyc(); cyc(); #1;
    chk("rst_ready_in", req_ready_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reseed", reseed, 0);
    chk("rst_outst", dut.r_outst, 0);
    cyc(); reset = 1'b0; #1;
    chk("idle_ready_in", req_ready_in, 1);
    chk("idle_busy", busy, 0);

    // 1: interval of 3 accepted requests, responses retire reads so DRAIN lasts one cycle
    cfg_interval = 24'd3;
    req_valid_in = 4'b0001; #1;
    chk("t1_valid_out", req_valid_out, 4'b0001);
    cyc();
    rsp_valid = 4'b0001; rsp_ready = 1'b1;
    cyc();
    rsp_valid = 4'b0011; #1;
    chk("t1_thresh_busy", busy, 0);
    chk("t1_thresh_ready", req_ready_in, 1);
    cyc();
    idle_in(); req_valid_in = 4'b0010; #1;
    base = pulses;
    chk("t1_gate_valid", req_valid_out, 4'b0000);
    chk("t1_gate_ready", req_ready_in, 0);
    for (int k = 0; k < 6; k++) begin
      chk("t1_busy_win", busy, 1);
      chk("t1_reseed_win", reseed, (k == 1) ? 1 : 0);
      if (k == 5) idle_in();
      cyc();
    end
    chk("t1_reopen_busy", busy, 0);
    req_ready_out = 1'b0; #1;
    chk("t1_follow_lo", req_ready_in, 0);
    req_ready_out = 1'b1; #1;
    chk("t1_follow_hi", req_ready_in, 1);
    chk("t1_pulses", pulses - base, 1);
    req_valid_in = 4'b0001; req_rw_in = 4'b0001;
    cyc(); idle_in(); cyc();
    chk("t1_icnt_cleared", busy, 0);

    // 2: explicit reseed with two reads outstanding
    cfg_interval = '0;
    req_valid_in = 4'b0011; req_rw_in = 4'b0000;
    cyc();
    idle_in(); reseed_req = 1'b1;
    cyc();
    reseed_req = 1'b0; req_valid_in = 4'b0001; #1;
    base = pulses;
    chk("t2_gate_valid", req_valid_out, 4'b0000);
    chk("t2_busy", busy, 1);
    cyc(); cyc();
    rsp_valid = 4'b0001; rsp_ready = 1'b0;
    cyc();
    rsp_valid = 4'b0001; rsp_ready = 1'b1;
    cyc();
    idle_in();
    cyc();
    chk("t2_still_drain", reseed, 0);
    rsp_valid = 4'b0001; rsp_ready = 1'b1;
    cyc();
    idle_in(); #1;
    chk("t2_no_reseed_yet", reseed, 0);
    cyc();
    chk("t2_reseed", reseed, 1);
    for (int k = 0; k < 5; k++) cyc();
    chk("t2_reopen", busy, 0);
    chk("t2_pulses", pulses - base, 1);

    // 3: 4-lane fire (rw=0101 -> 2 reads) with one response in the same cycle
    req_valid_in = 4'b0001; req_rw_in = 4'b0000;
    cyc();
    req_valid_in = 4'b1111; req_rw_in = 4'b0101;
    rsp_valid = 4'b0001; rsp_ready = 1'b1; #1;
    chk("t3_valid_out", req_valid_out, 4'b1111);
    cyc();
    chk("t3_outst_net", dut.r_outst, 2);
    idle_in(); rsp_valid = 4'b0011; rsp_ready = 1'b1;
    cyc();
    idle_in(); #1;
    chk("t3_outst_zero", dut.r_outst, 0);

    // 4: second request during SETTLE is absorbed
    base = pulses;
    reseed_req = 1'b1;
    cyc();
    reseed_req = 1'b0;
    cyc(); cyc(); cyc();
    reseed_req = 1'b1;
    cyc();
    reseed_req = 1'b0;
    for (int k = 0; k < 12; k++) cyc();
    chk("t4_pulses", pulses - base, 1);
    chk("t4_idle", busy, 0);

    // 5: reset while draining
    req_valid_in = 4'b0001; req_rw_in = 4'b0000;
    cyc();
    idle_in(); reseed_req = 1'b1;
    cyc();
    reseed_req = 1'b0; #1;
    chk("t5_drain_busy", busy, 1);
    base = pulses;
    reset = 1'b1; #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready_in, 0);
    cyc();
    reset = 1'b0; #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_outst", dut.r_outst, 0);
    chk("t5_ready", req_ready_in, 1);
    for (int k = 0; k < 8; k++) cyc();
    chk("t5_no_reseed", pulses - base, 0);

`ifdef VX_RESEED_PERF_EN
    // 6: five stalled cycles across two reseeds
    reset = 1'b1;
    cyc();
    reset = 1'b0; #1;
    chk("t6_perf_rst_r", perf_reseeds, 0);
    chk("t6_perf_rst_s", perf_stall_cycles, 0);
    reseed_req = 1'b1;
    cyc();
    reseed_req = 1'b0; req_valid_in = 4'b0001; req_rw_in = 4'b1111;
    for (int k = 0; k < 5; k++) cyc();
    idle_in();
    cyc();
    reseed_req = 1'b1;
    cyc();
    reseed_req = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    chk("t6_perf_reseeds", perf_reseeds, 2);
    chk("t6_perf_stalls", perf_stall_cycles, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
